// File: rtl/rv32_writeback.sv
// rv32_writeback: final RV32 stage; aligns/extends load data and registers the register-file write port.
// Optional retire counter (instret_out, retire_out) enabled by RV32_WB_RETIRE_COUNT_EN.
module rv32_writeback #(
  parameter logic [31:0] RESET_PC_TAG = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_in,
  input  logic        flush_in,
  input  logic        valid_in,
  input  logic [31:0] pc_in,
  input  logic [4:0]  rd_in,
  input  logic        rd_write_in,
  input  logic        load_in,
  input  logic [1:0]  load_width_in,
  input  logic        load_unsigned_in,
  input  logic [1:0]  addr_low_in,
  input  logic [31:0] result_in,
  input  logic [31:0] read_data_in,
  output logic [31:0] pc_out,
  output logic [4:0]  rd_out,
  output logic        rd_write_out,
  output logic [31:0] rd_value_out,
  output logic        writeback_flush_out,
  output logic        misaligned_out
`ifdef RV32_WB_RETIRE_COUNT_EN
  ,
  output logic [63:0] instret_out,
  output logic        retire_out
`endif
);
  logic [31:0] w_shift;
  logic [15:0] w_half;
  logic [31:0] w_load;
  logic        w_mis;
  logic [31:0] w_value;
  logic        w_bubble;
  assign w_shift  = read_data_in >> {addr_low_in, 3'b000};
  assign w_half   = addr_low_in[1] ? read_data_in[31:16] : read_data_in[15:0];
  // width 3 (reserved) falls through to the full-word path
  assign w_load   = load_width_in == 2'd0 ? {{24{~load_unsigned_in & w_shift[7]}}, w_shift[7:0]} :
                    load_width_in == 2'd1 ? {{16{~load_unsigned_in & w_half[15]}}, w_half} :
                    read_data_in;
  assign w_mis    = load_in & ((load_width_in == 2'd1 & addr_low_in[0]) |
                               (load_width_in[1] & addr_low_in != 2'd0));
  assign w_value  = w_mis ? 32'h0 : load_in ? w_load : result_in;
  assign w_bubble = flush_in | ~valid_in;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_out              <= RESET_PC_TAG;
      rd_out              <= 5'd0;
      rd_write_out        <= 1'b0;
      rd_value_out        <= 32'h0;
      writeback_flush_out <= 1'b1;
      misaligned_out      <= 1'b0;
    end else if (!stall_in) begin
      pc_out              <= w_bubble ? RESET_PC_TAG : pc_in;
      writeback_flush_out <= w_bubble;
      misaligned_out      <= ~w_bubble & w_mis;
      rd_write_out        <= ~w_bubble & rd_write_in & (rd_in != 5'd0) & ~w_mis;
      if (!w_bubble) begin
        rd_out       <= rd_in;
        rd_value_out <= w_value;
      end
    end
  end
`ifdef RV32_WB_RETIRE_COUNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instret_out <= 64'h0;
      retire_out  <= 1'b0;
    end else if (!stall_in) begin
      retire_out  <= ~w_bubble & ~w_mis;
      instret_out <= instret_out + {63'h0, ~w_bubble & ~w_mis};
    end
  end
`endif
endmodule

// File: tb/tb_rv32_writeback.sv
// tb_rv32_writeback: scoreboard bench for rv32_writeback; expectations queued at drive time, popped after the edge.
module tb_rv32_writeback;
  localparam logic [31:0] T = 32'hBAD0_0000;
  logic        clk = 1'b0;
  logic        reset, stall_in, flush_in, valid_in, rd_write_in, load_in, load_unsigned_in;
  logic [31:0] pc_in, result_in, read_data_in;
  logic [4:0]  rd_in;
  logic [1:0]  load_width_in, addr_low_in;
  logic [31:0] pc_out, rd_value_out;
  logic [4:0]  rd_out;
  logic        rd_write_out, writeback_flush_out, misaligned_out;
`ifdef RV32_WB_RETIRE_COUNT_EN
  logic [63:0] instret_out;
  logic        retire_out;
  logic [63:0] exp_cnt = 64'h0;
`endif
  typedef struct packed {
    logic        flush;
    logic [4:0]  rd;
    logic        wr;
    logic [31:0] val;
    logic        mis;
    logic [31:0] pc;
  } exp_t;
  exp_t q[$];
  int n_vec = 0;
  int n_err = 0;
  rv32_writeback #(.RESET_PC_TAG(T)) dut (
    .clk(clk), .reset(reset), .stall_in(stall_in), .flush_in(flush_in), .valid_in(valid_in),
    .pc_in(pc_in), .rd_in(rd_in), .rd_write_in(rd_write_in), .load_in(load_in),
    .load_width_in(load_width_in), .load_unsigned_in(load_unsigned_in), .addr_low_in(addr_low_in),
    .result_in(result_in), .read_data_in(read_data_in), .pc_out(pc_out), .rd_out(rd_out),
    .rd_write_out(rd_write_out), .rd_value_out(rd_value_out),
    .writeback_flush_out(writeback_flush_out), .misaligned_out(misaligned_out)
`ifdef RV32_WB_RETIRE_COUNT_EN
    , .instret_out(instret_out), .retire_out(retire_out)
`endif
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic check_out();
    exp_t e;
    e = q.pop_front();
    chk("flush", 64'(writeback_flush_out), 64'(e.flush));
    chk("rd", 64'(rd_out), 64'(e.rd));
    chk("rd_write", 64'(rd_write_out), 64'(e.wr));
    chk("rd_value", 64'(rd_value_out), 64'(e.val));
    chk("misaligned", 64'(misaligned_out), 64'(e.mis));
    chk("pc", 64'(pc_out), 64'(e.pc));
`ifdef RV32_WB_RETIRE_COUNT_EN
    chk("retire", 64'(retire_out), 64'(!e.flush && !e.mis));
    chk("instret", instret_out, exp_cnt);
`endif
  endtask
  task automatic apply(input logic st, input logic fl, input logic v, input logic [31:0] pc,
                       input logic [4:0] rd, input logic wr, input logic ld, input logic [1:0] w,
                       input logic u, input logic [1:0] a, input logic [31:0] res,
                       input logic [31:0] rdata, input exp_t e);
    @(negedge clk);
    stall_in = st; flush_in = fl; valid_in = v; pc_in = pc; rd_in = rd; rd_write_in = wr;
    load_in = ld; load_width_in = w; load_unsigned_in = u; addr_low_in = a;
    result_in = res; read_data_in = rdata;
    q.push_back(e);
`ifdef RV32_WB_RETIRE_COUNT_EN
    if (!st && !e.flush && !e.mis) exp_cnt = exp_cnt + 64'd1;
`endif
    @(posedge clk);
    #1 check_out();
  endtask
  initial begin
    reset = 1'b1; stall_in = 0; flush_in = 0; valid_in = 0; pc_in = 0; rd_in = 0; rd_write_in = 0;
    load_in = 0; load_width_in = 0; load_unsigned_in = 0; addr_low_in = 0; result_in = 0; read_data_in = 0;
    #12;
    chk("rst_flush", 64'(writeback_flush_out), 64'd1);
    chk("rst_rd_write", 64'(rd_write_out), 64'd0);
    chk("rst_pc", 64'(pc_out), 64'(T));
    chk("rst_value", 64'(rd_value_out), 64'd0);
    chk("rst_mis", 64'(misaligned_out), 64'd0);
    @(negedge clk) reset = 1'b0;
    //     st fl v  pc           rd wr ld w  u  a  res            rdata               flush rd wr val  mis pc
    apply(0, 0, 0, 32'h0,       0, 0, 0, 0, 0, 0, 32'h0,         32'h0,          '{1, 0, 0, 32'h0, 0, T});
    apply(0, 0, 1, 32'h100,     5, 1, 1, 0, 0, 2, 32'h0,         32'h1280_3456,  '{0, 5, 1, 32'hFFFF_FF80, 0, 32'h100});
    apply(0, 0, 1, 32'h104,     5, 1, 1, 0, 1, 2, 32'h0,         32'h1280_3456,  '{0, 5, 1, 32'h0000_0080, 0, 32'h104});
    apply(0, 0, 1, 32'h108,     6, 1, 1, 1, 0, 2, 32'h0,         32'h8001_7FFF,  '{0, 6, 1, 32'hFFFF_8001, 0, 32'h108});
    apply(0, 0, 1, 32'h10C,     6, 1, 1, 2, 0, 1, 32'h0,         32'h8001_7FFF,  '{0, 6, 0, 32'h0, 1, 32'h10C});
    apply(0, 0, 0, 32'h0,       9, 1, 0, 0, 0, 0, 32'h1234,      32'h0,          '{1, 6, 0, 32'h0, 0, T});
    apply(0, 0, 1, 32'h110,     0, 1, 0, 0, 0, 0, 32'hDEAD_BEEF, 32'h0,          '{0, 0, 0, 32'hDEAD_BEEF, 0, 32'h110});
    apply(0, 0, 1, 32'h114,     9, 1, 1, 1, 1, 0, 32'h0,         32'h8001_7FFF,  '{0, 9, 1, 32'h0000_7FFF, 0, 32'h114});
    apply(0, 0, 1, 32'h118,    10, 1, 1, 0, 0, 3, 32'h0,         32'h7F00_00FF,  '{0, 10, 1, 32'h0000_007F, 0, 32'h118});
    apply(0, 0, 1, 32'h11C,    11, 1, 1, 3, 0, 0, 32'h0,         32'hA5A5_5A5A,  '{0, 11, 1, 32'hA5A5_5A5A, 0, 32'h11C});
    apply(0, 0, 1, 32'h120,    12, 1, 1, 1, 0, 1, 32'h0,         32'hA5A5_5A5A,  '{0, 12, 0, 32'h0, 1, 32'h120});
    apply(1, 0, 1, 32'h200,    13, 1, 0, 0, 0, 0, 32'h77,        32'h0,          '{0, 12, 0, 32'h0, 1, 32'h120});
    apply(0, 0, 1, 32'h124,     7, 1, 0, 0, 0, 0, 32'h11,        32'h0,          '{0, 7, 1, 32'h11, 0, 32'h124});
    for (int i = 0; i < 3; i++)
      apply(1, 1, 1, 32'h300,  8, 1, 0, 0, 0, 0, 32'h99,        32'h0,          '{0, 7, 1, 32'h11, 0, 32'h124});
    apply(0, 1, 1, 32'h300,     8, 1, 0, 0, 0, 0, 32'h99,        32'h0,          '{1, 7, 0, 32'h11, 0, T});
    apply(0, 0, 1, 32'h128,     3, 1, 0, 0, 0, 0, 32'h55,        32'h0,          '{0, 3, 1, 32'h55, 0, 32'h128});
    @(negedge clk);
    stall_in = 1'b1;
    #2 reset = 1'b1;
    #1;
    chk("async_flush", 64'(writeback_flush_out), 64'd1);
    chk("async_rd", 64'(rd_out), 64'd0);
    chk("async_wr", 64'(rd_write_out), 64'd0);
    chk("async_value", 64'(rd_value_out), 64'd0);
    chk("async_pc", 64'(pc_out), 64'(T));
`ifdef RV32_WB_RETIRE_COUNT_EN
    chk("async_instret", instret_out, 64'd0);
    exp_cnt = 64'h0;
`endif
    @(negedge clk) reset = 1'b0;
    apply(0, 0, 1, 32'h12C,     4, 1, 0, 0, 0, 0, 32'hC0DE,      32'h0,          '{0, 4, 1, 32'hC0DE, 0, 32'h12C});
    if (q.size() != 0) chk("queue_empty", 64'(q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
